// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller.
// The nesting option is controlled by the INTC_NESTING_EN macro; see interrupt_controller.sv.
package intc_pkg;

    // Sequencing states for interrupt entry and return
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

    localparam logic [15:0] RESET_BASE_DEFAULT = 16'h0010;

    // Wide enough to index up to 16 request lines
    localparam int IDX_W = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Lowest set index wins (index 0 is highest priority)
    function automatic prio_t prio_encode(input logic [15:0] vec);
        prio_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational N-input priority encoder: reports the lowest set index and whether any bit is set.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [15:0] vec_ext;
    prio_t       res;

    // Zero-extend to the helper's fixed width, then encode
    always_comb begin
        vec_ext        = '0;
        vec_ext[N-1:0] = vec;
        res            = prio_encode(vec_ext);
    end

    assign valid = res.valid;
    assign idx   = res.idx;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: edge-detected pending register, mask, single request
// to the control unit, vector/pending drive onto the shared d_bus and in-service tracking.
// Optional macro INTC_NESTING_EN: allows a higher-priority source to preempt an active handler.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          N_IRQ      = 8,
    parameter int          VEC_SHIFT  = 2,
    parameter logic [15:0] RESET_BASE = RESET_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    output logic             int_req,
    input  logic             int_ack,
    input  logic             int_ret,
    input  logic             push_ints,
    input  logic             push_int_addr,
    input  logic             load_mask,
    input  logic             load_base,
    inout  wire  [15:0]      d_bus
);

    logic [N_IRQ-1:0] irq_q_reg;
    logic [N_IRQ-1:0] pending_reg;
    logic [N_IRQ-1:0] mask_reg;
    logic [15:0]      base_reg;
    logic [N_IRQ-1:0] in_service_reg;
    logic [IDX_W-1:0] ack_idx_reg;
    intc_state_t      state_reg;
    logic             int_req_reg;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] pending_next;
    logic [N_IRQ-1:0] in_service_next;
    logic [N_IRQ-1:0] win_onehot;
    logic [N_IRQ-1:0] ret_onehot;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic             svc_valid;
    logic [IDX_W-1:0] svc_idx;
    logic             eligible;
    logic             ack_take;
    logic             ret_take;
    logic [15:0]      vector;
    logic [15:0]      active_ext;
    logic [15:0]      bus_out;

    assign rise   = irq & ~irq_q_reg;
    assign active = pending_reg & mask_reg;

    intc_prio_enc #(.N(N_IRQ)) u_win_enc (
        .vec   (active),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Highest-priority in-service source; in single-level mode only the acked bit can be set,
    // so this is the same as ack_idx there.
    intc_prio_enc #(.N(N_IRQ)) u_svc_enc (
        .vec   (in_service_reg),
        .valid (svc_valid),
        .idx   (svc_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_dec
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
            assign ret_onehot[gi] = (svc_idx == IDX_W'(gi));
        end
    endgenerate

`ifdef INTC_NESTING_EN
    logic [N_IRQ-1:0] svc_rest;
    logic             rest_valid;
    logic [IDX_W-1:0] rest_idx;

    // Source that becomes current once the innermost handler returns
    assign svc_rest = in_service_reg & ~ret_onehot;

    intc_prio_enc #(.N(N_IRQ)) u_rest_enc (
        .vec   (svc_rest),
        .valid (rest_valid),
        .idx   (rest_idx)
    );

    assign eligible = !svc_valid || (win_idx < svc_idx);
`else
    assign eligible = !svc_valid;
`endif

    // Acceptance is evaluated against registered mask, so a same-cycle load_mask does not affect it
    assign ack_take = (state_reg == REQ) && int_ack && win_valid && eligible;
    assign ret_take = (state_reg == SERVICE) && int_ret;

    // A new rise on the acked bit re-sets pending (set beats clear)
    assign pending_next    = (pending_reg & ~(ack_take ? win_onehot : '0)) | rise;
    assign in_service_next = (in_service_reg & ~(ret_take ? ret_onehot : '0))
                           | (ack_take ? win_onehot : '0);

    // Request capture, mask/base registers and in-service bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q_reg      <= irq;
            pending_reg    <= '0;
            mask_reg       <= '0;
            base_reg       <= RESET_BASE;
            in_service_reg <= '0;
        end else begin
            irq_q_reg      <= irq;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            if (load_mask) begin
                mask_reg <= d_bus[N_IRQ-1:0];
            end
            if (load_base) begin
                base_reg <= d_bus;
            end
        end
    end

    // Entry/return sequencer with registered request output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            int_req_reg <= 1'b0;
            ack_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid && eligible) begin
                        state_reg   <= REQ;
                        int_req_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (!(win_valid && eligible)) begin
                        // Request withdrawn (e.g. masked off); any later ack is ignored
                        int_req_reg <= 1'b0;
                        state_reg   <= svc_valid ? SERVICE : IDLE;
                    end else if (int_ack) begin
                        ack_idx_reg <= win_idx;
                        int_req_reg <= 1'b0;
                        state_reg   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_ret) begin
`ifdef INTC_NESTING_EN
                        if (rest_valid) begin
                            ack_idx_reg <= rest_idx;
                            state_reg   <= SERVICE;
                        end else begin
                            state_reg   <= IDLE;
                        end
`else
                        state_reg <= IDLE;
`endif
                    end
`ifdef INTC_NESTING_EN
                    else if (win_valid && eligible) begin
                        state_reg   <= REQ;
                        int_req_reg <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_reg   <= IDLE;
                    int_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign int_req = int_req_reg;

    // 16-bit wrap-around vector for the acknowledged source
    assign vector = base_reg + (16'(ack_idx_reg) << VEC_SHIFT);

    // Select bus data; vector has priority over the pending word
    always_comb begin
        active_ext              = '0;
        active_ext[N_IRQ-1:0]   = active;
        bus_out                 = push_int_addr ? vector : active_ext;
    end

    assign d_bus = (push_ints || push_int_addr) ? bus_out : 16'hzzzz;

endmodule
